// File: rtl/proc_pkg.sv
// Shared processor types: arbiter state encoding, requester ids and default widths.
package proc_pkg;

    localparam int PROC_AW = 8;
    localparam int PROC_DW = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    localparam logic ARB_F = 1'b0;
    localparam logic ARB_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (fetch F, load/store D) for the single-port synchronous RAM.
// Optional F anti-starvation streak limit is compiled in with MEMARB_FAIR_EN.
//
// state  | meaning
// IDLE   | pick a winner, handshake latches the request
// ACCESS | mem_en strobe for one cycle, latency counter loaded
// WAIT   | count down RAM latency, capture read data at zero
// RESP   | one-cycle rsp_valid pulse to the winner
import proc_pkg::*;

module mem_port_arbiter #(
    parameter int AW         = PROC_AW,
    parameter int DW         = PROC_DW,
    parameter int MEM_LAT    = 1,
    parameter int MAX_STREAK = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          f_req_valid,
    input  logic [AW-1:0] f_req_addr,
    output logic          f_req_ready,
    output logic          f_rsp_valid,
    output logic [DW-1:0] f_rsp_data,
    input  logic          d_req_valid,
    input  logic          d_req_we,
    input  logic [AW-1:0] d_req_addr,
    input  logic [DW-1:0] d_req_wdata,
    output logic          d_req_ready,
    output logic          d_rsp_valid,
    output logic [DW-1:0] d_rsp_data,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int LCW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    if (MEM_LAT < 1) begin : g_bad_lat
        $error("mem_port_arbiter: MEM_LAT must be >= 1");
    end
    if (MAX_STREAK < 1) begin : g_bad_streak
        $error("mem_port_arbiter: MAX_STREAK must be >= 1");
    end

    arb_state_t    state_q, state_d;
    logic [LCW-1:0] lat_q, lat_d;
    logic          id_q;
    logic          we_q;
    logic          mem_en_q, mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [DW-1:0] f_rsp_data_q, d_rsp_data_q;
    logic          f_wins;
    logic          f_hs, d_hs;

`ifdef MEMARB_FAIR_EN
    localparam int SW = $clog2(MAX_STREAK + 1);
    logic [SW-1:0] streak_q;

    // F takes the port once D has won MAX_STREAK times in a row over a waiting F
    assign f_wins = f_req_valid && (!d_req_valid || streak_q == SW'(MAX_STREAK));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak_q <= '0;
        end else if (d_hs) begin
            streak_q <= f_req_valid ? streak_q + SW'(1) : '0;
        end else if (f_hs) begin
            streak_q <= '0;
        end
    end
`else
    assign f_wins = f_req_valid && !d_req_valid;
`endif

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        f_req_ready = 1'b0;
        d_req_ready = 1'b0;
        case (state_q)
            IDLE: begin
                f_req_ready = !reset && f_req_valid && f_wins;
                d_req_ready = !reset && d_req_valid && !f_wins;
                if (f_req_ready || d_req_ready) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                state_d = WAIT;
                lat_d   = LCW'(MEM_LAT - 1);
            end
            WAIT: begin
                if (lat_q == '0) begin
                    state_d = RESP;
                end else begin
                    lat_d = lat_q - LCW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign f_hs = f_req_valid && f_req_ready;
    assign d_hs = d_req_valid && d_req_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            lat_q        <= '0;
            id_q         <= ARB_F;
            we_q         <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            f_rsp_data_q <= '0;
            d_rsp_data_q <= '0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            // strobes are only set on the handshake edge, so they live exactly in ACCESS
            mem_en_q <= f_hs || d_hs;
            mem_we_q <= d_hs && d_req_we;
            if (d_hs) begin
                id_q        <= ARB_D;
                we_q        <= d_req_we;
                mem_addr_q  <= d_req_addr;
                mem_wdata_q <= d_req_wdata;
            end else if (f_hs) begin
                id_q       <= ARB_F;
                we_q       <= 1'b0;
                mem_addr_q <= f_req_addr;
            end
            if (state_q == WAIT && lat_q == '0) begin
                if (id_q == ARB_F) begin
                    f_rsp_data_q <= mem_rdata;
                end else begin
                    d_rsp_data_q <= we_q ? '0 : mem_rdata;
                end
            end
        end
    end

    assign f_rsp_valid = (state_q == RESP) && (id_q == ARB_F);
    assign d_rsp_valid = (state_q == RESP) && (id_q == ARB_D);
    assign f_rsp_data  = f_rsp_data_q;
    assign d_rsp_data  = d_rsp_data_q;
    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: one MEM_LAT=1 instance with a RAM model, one MEM_LAT=3 instance.
module tb_mem_port_arbiter;

    localparam int LAT1 = 1;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic        f_valid, f_ready, f_rsp_valid;
    logic [7:0]  f_addr;
    logic [15:0] f_rsp_data;
    logic        d_valid, d_we, d_ready, d_rsp_valid;
    logic [7:0]  d_addr;
    logic [15:0] d_wdata, d_rsp_data;
    logic        mem_en, mem_we, busy;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;

    logic        f2_valid, f2_ready, f2_rsp_valid;
    logic [7:0]  f2_addr;
    logic [15:0] f2_rsp_data;
    logic        d2_valid, d2_we, d2_ready, d2_rsp_valid;
    logic [7:0]  d2_addr;
    logic [15:0] d2_wdata, d2_rsp_data;
    logic        mem_en2, mem_we2, busy2;
    logic [7:0]  mem_addr2;
    logic [15:0] mem_wdata2, mem_rdata2;

    logic [15:0] ram   [256];
    logic [15:0] ram2  [256];
    logic [15:0] model [256];
    logic [15:0] rd0;
    logic [15:0] rp0, rp1, rp2;

    exp_t fq[$];
    exp_t dq[$];
    bit   glog[$];
    int   hs_cyc = -100;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mem_port_arbiter #(.MEM_LAT(LAT1)) u_dut (
        .clk(clk), .reset(reset),
        .f_req_valid(f_valid), .f_req_addr(f_addr), .f_req_ready(f_ready),
        .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data),
        .d_req_valid(d_valid), .d_req_we(d_we), .d_req_addr(d_addr), .d_req_wdata(d_wdata),
        .d_req_ready(d_ready), .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.MEM_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .f_req_valid(f2_valid), .f_req_addr(f2_addr), .f_req_ready(f2_ready),
        .f_rsp_valid(f2_rsp_valid), .f_rsp_data(f2_rsp_data),
        .d_req_valid(d2_valid), .d_req_we(d2_we), .d_req_addr(d2_addr), .d_req_wdata(d2_wdata),
        .d_req_ready(d2_ready), .d_rsp_valid(d2_rsp_valid), .d_rsp_data(d2_rsp_data),
        .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_rdata(mem_rdata2), .busy(busy2)
    );

    // RAM models: read data only appears exactly LAT cycles after an mem_en cycle
    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        rd0 <= mem_en ? ram[mem_addr] : 16'hDEAD;
        rp0 <= mem_en2 ? ram2[mem_addr2] : 16'hDEAD;
        rp1 <= rp0;
        rp2 <= rp1;
    end
    assign mem_rdata  = rd0;
    assign mem_rdata2 = rp2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            exp_t e;
            if (f_ready && d_ready) chk("both_ready", 1, 0);
            if (f_valid && f_ready) begin
                e.data = model[f_addr];
                e.cyc  = cyc + LAT1 + 2;
                fq.push_back(e);
                glog.push_back(1'b0);
                hs_cyc = cyc;
            end
            if (d_valid && d_ready) begin
                if (d_we) begin
                    model[d_addr] = d_wdata;
                    e.data = 16'h0;
                end else begin
                    e.data = model[d_addr];
                end
                e.cyc = cyc + LAT1 + 2;
                dq.push_back(e);
                glog.push_back(1'b1);
                hs_cyc = cyc;
            end
            if (mem_en) chk("mem_en_cyc", cyc, hs_cyc + 1);
            if (f_rsp_valid) begin
                if (fq.size() == 0) begin
                    chk("f_rsp_unexpected", 1, 0);
                end else begin
                    e = fq.pop_front();
                    chk("f_rsp_data", f_rsp_data, e.data);
                    chk("f_rsp_cyc", cyc, e.cyc);
                end
            end
            if (d_rsp_valid) begin
                if (dq.size() == 0) begin
                    chk("d_rsp_unexpected", 1, 0);
                end else begin
                    e = dq.pop_front();
                    chk("d_rsp_data", d_rsp_data, e.data);
                    chk("d_rsp_cyc", cyc, e.cyc);
                end
            end
        end
    end

    task automatic wait_ready(input bit is_f, output int c);
        bit ok = 1'b0;
        c = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (is_f ? f_ready : d_ready) begin
                ok = 1'b1;
                c  = cyc;
                break;
            end
        end
        if (!ok) chk(is_f ? "f_ready_timeout" : "d_ready_timeout", 0, 1);
    endtask

    task automatic f_req(input logic [7:0] a);
        int c;
        @(posedge clk); #1;
        f_valid = 1'b1;
        f_addr  = a;
        wait_ready(1'b1, c);
        @(posedge clk); #1;
        f_valid = 1'b0;
    endtask

    task automatic d_req(input logic we, input logic [7:0] a, input logic [15:0] wd);
        int c;
        @(posedge clk); #1;
        d_valid = 1'b1;
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        wait_ready(1'b0, c);
        @(posedge clk); #1;
        d_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fq.size() == 0 && dq.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 0, 1);
    endtask

    task automatic wait_glog(input int n);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (glog.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("grant_timeout", glog.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c, dc, fc;
        bit exp_order[7];

        f_valid = 0; f_addr = 0; d_valid = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        f2_valid = 0; f2_addr = 0; d2_valid = 0; d2_we = 0; d2_addr = 0; d2_wdata = 0;
        for (int i = 0; i < 256; i++) begin
            ram[i]   = 16'(i * 7 + 3);
            ram2[i]  = 16'(i * 7 + 3);
            model[i] = 16'(i * 7 + 3);
        end
        ram[8'h10]   = 16'hBEEF;
        model[8'h10] = 16'hBEEF;
        ram2[8'h30]  = 16'hCAFE;

        // reset state, with valids raised to prove readies are held off
        repeat (2) @(posedge clk);
        #1;
        f_valid = 1'b1;
        d_valid = 1'b1;
        #1;
        chk("rst_f_ready", f_ready, 0);
        chk("rst_d_ready", d_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_f_rsp_valid", f_rsp_valid, 0);
        chk("rst_d_rsp_data", d_rsp_data, 0);
        chk("rst_busy2", busy2, 0);
        f_valid = 1'b0;
        d_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;

        // single fetch
        f_req(8'h10);
        drain();

        // store then load back
        d_req(1'b1, 8'h20, 16'h1234);
        d_req(1'b0, 8'h20, 16'h0);
        drain();
        chk("d_rsp_data_hold", d_rsp_data, 16'h1234);

        // simultaneous requests: D first, F in the IDLE cycle after D's RESP
        @(posedge clk); #1;
        f_valid = 1'b1; f_addr = 8'h21;
        d_valid = 1'b1; d_we = 1'b0; d_addr = 8'h22;
        wait_ready(1'b0, dc);
        chk("t3_f_held_off", f_ready, 0);
        @(posedge clk); #1;
        d_valid = 1'b0;
        wait_ready(1'b1, fc);
        chk("t3_f_grant_cyc", fc, dc + LAT1 + 3);
        @(posedge clk); #1;
        f_valid = 1'b0;
        drain();

        // both held valid: grant order
        glog.delete();
        @(posedge clk); #1;
        f_valid = 1'b1; f_addr = 8'h10;
        d_valid = 1'b1; d_we = 1'b0; d_addr = 8'h22;
        wait_glog(6);
        @(posedge clk); #1;
        d_valid = 1'b0;
        wait_glog(7);
        @(posedge clk); #1;
        f_valid = 1'b0;
        drain();
`ifdef MEMARB_FAIR_EN
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
        chk("t4_grant_count", glog.size(), 7);
        for (int i = 0; i < 7 && i < glog.size(); i++) begin
            chk($sformatf("t4_grant%0d", i), glog[i], exp_order[i]);
        end

        // reset during WAIT drops the access
        @(posedge clk); #1;
        f_valid = 1'b1; f_addr = 8'h10;
        wait_ready(1'b1, c);
        @(posedge clk); #1;
        f_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("t5_busy_before_rst", busy, 1);
        reset = 1'b1;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_mem_en", mem_en, 0);
        chk("t5_mem_addr", mem_addr, 0);
        chk("t5_mem_wdata", mem_wdata, 0);
        chk("t5_f_rsp_valid", f_rsp_valid, 0);
        chk("t5_f_rsp_data", f_rsp_data, 0);
        fq.delete();
        dq.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) @(negedge clk);
        f_req(8'h10);
        drain();

        // MEM_LAT=3 instance: response at handshake+5, busy through it
        @(posedge clk); #1;
        f2_valid = 1'b1; f2_addr = 8'h30;
        begin
            bit ok = 1'b0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (f2_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) chk("f2_ready_timeout", 0, 1);
        end
        @(posedge clk); #1;
        f2_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("t6_busy_k%0d", k), busy2, (k <= 5));
            chk($sformatf("t6_mem_en_k%0d", k), mem_en2, (k == 1));
            chk($sformatf("t6_rsp_valid_k%0d", k), f2_rsp_valid, (k == 5));
            if (k == 5) chk("t6_rsp_data", f2_rsp_data, 16'hCAFE);
        end

        repeat (5) @(negedge clk);
        chk("f_queue_empty", fq.size(), 0);
        chk("d_queue_empty", dq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
